stack_memory_responder: RTL and testbench
=========================================

Name: stack_memory_responder

Overview:
- Memory-side responder for the address/stack handler: accepts one request per handshake (op code, address, write data, mode) and performs the access on a synchronous data RAM.
- Returns read data or a write acknowledge on a valid/ready response channel.
- Flags stack-bound and address-range faults.
- Sits between the datapath's address handler and the data memory.

Parameters:
- WORD_SIZE, 32, data and address width.
- MEM_DEPTH, 8192, number of RAM words; legal addresses are 0..MEM_DEPTH-1.
- MEM_LATENCY, 1, cycles from the address being presented to the RAM until mem_read_data is valid (1..7).
- KERNEL_STACK_TOP, 4096, lowest legal kernel stack address.
- KERNEL_STACK_BOTTOM, 6143, highest legal kernel stack address.
- USER_STACK_TOP, 6144, lowest legal user stack address.
- USER_STACK_BOTTOM, 8191, highest legal user stack address.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_op  input  3  1=push, 2=pop, 3=ALU SP access, 4=branch/link access, other=plain access.
- req_write  input  1  1=store, 0=load.
- req_address  input  WORD_SIZE  word address.
- req_data  input  WORD_SIZE  store data.
- is_kernel  input  1  mode sampled with the request.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  WORD_SIZE  load data; 0 for stores and faults.
- resp_fault  output  1  request rejected.
- mem_address  output  WORD_SIZE  RAM address.
- mem_write_enable  output  1  RAM write strobe.
- mem_write_data  output  WORD_SIZE  RAM write data.
- mem_read_data  input  WORD_SIZE  RAM read data.

Behaviour:
- All outputs are registered except req_ready, which equals (state==IDLE).
- Reset (asynchronous) forces:
  - state=IDLE;
  - resp_valid, resp_fault, mem_write_enable = 0;
  - resp_data, mem_address, mem_write_data = 0;
  - latency counter = 0.
- Reset mid-operation abandons the request. No write strobe may appear after reset deasserts until a new request is accepted.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On req_valid, the request is captured together with is_kernel.
  - A fault check is computed (see Optional Feature).
  - Fault: go to RESP with resp_fault=1, resp_data=0. The RAM is untouched and mem_write_enable stays 0.
  - No fault: load mem_address/mem_write_data and go to ACCESS.
- ACCESS, store:
  - mem_write_enable=1 for exactly one cycle.
  - Next state is RESP with resp_data=0, resp_fault=0.
- ACCESS, load:
  - Counter counts MEM_LATENCY cycles with mem_write_enable=0.
  - On the last count, resp_data captures mem_read_data; next state is RESP.
- RESP:
  - resp_valid=1; resp_data and resp_fault are held stable until resp_ready.
  - On resp_valid and resp_ready, resp_valid falls and the next state is IDLE.
- Latency, acceptance edge to resp_valid high:
  - store: 2 cycles;
  - load: 1+MEM_LATENCY cycles;
  - fault: 1 cycle.
- Throughput: one outstanding request; req_ready stays low from acceptance until response completion.
- Address range fault (always active): req_address >= MEM_DEPTH faults for any op.
- Bound checks use an unsigned comparison on the full WORD_SIZE address; no wrap-around.

Optional Feature:
- Macro: STACK_BOUND_CHECK_EN.
- Defined:
  - A push (op 1) or pop (op 2) faults if the address is outside [TOP, BOTTOM] inclusive.
  - TOP/BOTTOM are the kernel bounds when the captured is_kernel=1, otherwise the user bounds.
  - Other ops are checked only for range.
- Undefined: only the address range check applies, and push/pop to any in-range address proceeds.

Test Plan:
- Store op 0, addr 100, data 0xDEADBEEF, resp_ready=1 -> one cycle with mem_write_enable=1, mem_address=100; resp_valid 2 cycles after acceptance with resp_data=0, resp_fault=0.
- Load op 0, addr 100, MEM_LATENCY=3, RAM returns 0xDEADBEEF -> resp_valid 4 cycles after acceptance, resp_data=0xDEADBEEF; req_ready low throughout.
- With STACK_BOUND_CHECK_EN, push addr 4095, is_kernel=1 -> resp_fault=1 one cycle after acceptance, no write strobe.
  - Same push with is_kernel=0 at addr 6144 -> normal write.
  - Without the macro, the 4095 push writes.
- Load addr 8192 (MEM_DEPTH=8192), any op -> resp_fault=1, resp_data=0.
- Response backpressure: resp_ready low for 5 cycles -> resp_valid and resp_data stable, req_ready low; a second request is not accepted until the cycle after resp_ready rises.
- Reset asserted during ACCESS of a store with MEM_LATENCY=3 load pending -> all outputs 0 immediately, state IDLE, req_ready=1 after release, no mem_write_enable pulse.

Source files
------------

// File: rtl/stack_memory_responder.sv
// Memory-side responder: one request at a time, performs a RAM access and returns data or a fault.
// Optional macro STACK_BOUND_CHECK_EN adds push/pop stack-bound checking on top of the range check.
module stack_memory_responder #(
  parameter int WORD_SIZE           = 32,
  parameter int MEM_DEPTH           = 8192,
  parameter int MEM_LATENCY         = 1,
  parameter int KERNEL_STACK_TOP    = 4096,
  parameter int KERNEL_STACK_BOTTOM = 6143,
  parameter int USER_STACK_TOP      = 6144,
  parameter int USER_STACK_BOTTOM   = 8191
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_address,
  input  logic [WORD_SIZE-1:0] req_data,
  input  logic                 is_kernel,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_fault,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic                 mem_write_enable,
  output logic [WORD_SIZE-1:0] mem_write_data,
  input  logic [WORD_SIZE-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [WORD_SIZE-1:0] C_DEPTH    = WORD_SIZE'(MEM_DEPTH);
  localparam logic [2:0]           C_LAST_CNT = 3'(MEM_LATENCY - 1);

  state_t     r_state;
  logic       r_write;
  logic [2:0] r_count;

  logic w_rangeFault;
  logic w_stackFault;
  logic w_fault;

  assign w_rangeFault = (req_address >= C_DEPTH);

`ifdef STACK_BOUND_CHECK_EN
  localparam logic [WORD_SIZE-1:0] C_K_TOP = WORD_SIZE'(KERNEL_STACK_TOP);
  localparam logic [WORD_SIZE-1:0] C_K_BOT = WORD_SIZE'(KERNEL_STACK_BOTTOM);
  localparam logic [WORD_SIZE-1:0] C_U_TOP = WORD_SIZE'(USER_STACK_TOP);
  localparam logic [WORD_SIZE-1:0] C_U_BOT = WORD_SIZE'(USER_STACK_BOTTOM);

  logic [WORD_SIZE-1:0] w_top;
  logic [WORD_SIZE-1:0] w_bottom;
  logic                 w_isStackOp;

  assign w_top        = is_kernel ? C_K_TOP : C_U_TOP;
  assign w_bottom     = is_kernel ? C_K_BOT : C_U_BOT;
  assign w_isStackOp  = (req_op == 3'd1) || (req_op == 3'd2);
  assign w_stackFault = w_isStackOp && ((req_address < w_top) || (req_address > w_bottom));
`else
  logic w_unused;
  assign w_unused = ^{req_op, is_kernel, 32'(KERNEL_STACK_TOP), 32'(KERNEL_STACK_BOTTOM),
                      32'(USER_STACK_TOP), 32'(USER_STACK_BOTTOM)};
  assign w_stackFault = 1'b0;
`endif

  assign w_fault   = w_rangeFault || w_stackFault;
  assign req_ready = (r_state == IDLE);

  // Write strobe is raised on acceptance so it spans exactly the single ACCESS cycle of a store.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_write          <= 1'b0;
      r_count          <= 3'd0;
      resp_valid       <= 1'b0;
      resp_fault       <= 1'b0;
      resp_data        <= '0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_count <= 3'd0;
            if (w_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_data  <= '0;
              r_state    <= RESP;
            end else begin
              mem_address      <= req_address;
              mem_write_data   <= req_data;
              mem_write_enable <= req_write;
              r_state          <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (r_write) begin
            mem_write_enable <= 1'b0;
            resp_valid       <= 1'b1;
            resp_fault       <= 1'b0;
            resp_data        <= '0;
            r_state          <= RESP;
          end else if (r_count == C_LAST_CNT) begin
            r_count    <= 3'd0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_data  <= mem_read_data;
            r_state    <= RESP;
          end else begin
            r_count <= r_count + 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_data  <= '0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_memory_responder.sv
// Scoreboard bench for stack_memory_responder with a latency-3 RAM model.
// Honours STACK_BOUND_CHECK_EN when computing expected faults.
module tb_stack_memory_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 8192;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic        is_kernel;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          latency;
    int          writes;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
  } expect_t;

  expect_t sbQueue[$];

  logic [31:0] ram    [0:DEPTH-1];
  logic [31:0] shadow [0:DEPTH-1];
  logic [31:0] rdPipe [0:LAT-1];
  int          wePulses = 0;
  logic [31:0] lastWrAddr = '0;
  logic [31:0] lastWrData = '0;

  stack_memory_responder #(
    .WORD_SIZE(32), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT),
    .KERNEL_STACK_TOP(4096), .KERNEL_STACK_BOTTOM(6143),
    .USER_STACK_TOP(6144), .USER_STACK_BOTTOM(8191)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_write(req_write), .req_address(req_address), .req_data(req_data),
    .is_kernel(is_kernel), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // RAM model: data for a held address becomes sampleable LAT edges after it is presented.
  always_comb begin
    rdPipe[0] = (mem_address < DEPTH) ? ram[mem_address[12:0]] : 32'd0;
  end
  assign mem_read_data = rdPipe[LAT-1];

  always @(posedge clock) begin
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    if (mem_write_enable) begin
      wePulses   <= wePulses + 1;
      lastWrAddr <= mem_address;
      lastWrData <= mem_write_data;
      if (mem_address < DEPTH) ram[mem_address[12:0]] <= mem_write_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic expectFault(input logic [2:0] op, input logic [31:0] addr, input logic kern);
    logic f;
    f = (addr >= DEPTH);
`ifdef STACK_BOUND_CHECK_EN
    if (op == 3'd1 || op == 3'd2) begin
      if (kern) f = f || (addr < 4096) || (addr > 6143);
      else      f = f || (addr < 6144) || (addr > 8191);
    end
`endif
    return f;
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic kern, input int hold);
    expect_t     e;
    expect_t     got;
    int          startPulses;
    int          lat;
    logic [31:0] heldData;
    logic        heldFault;

    @(negedge clock);
    e.fault   = expectFault(op, addr, kern);
    e.data    = (e.fault || wr) ? 32'd0 : shadow[addr[12:0]];
    e.latency = e.fault ? 1 : (wr ? 2 : 1 + LAT);
    e.writes  = (!e.fault && wr) ? 1 : 0;
    e.wrAddr  = addr;
    e.wrData  = data;
    if (!e.fault && wr) shadow[addr[12:0]] = data;
    sbQueue.push_back(e);

    checkOutput({tag, ".reqReadyIdle"}, 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_op      = op;
    req_write   = wr;
    req_address = addr;
    req_data    = data;
    is_kernel   = kern;
    resp_ready  = (hold == 0);
    startPulses = wePulses;

    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      checkOutput({tag, ".reqReadyBusy"}, 64'(req_ready), 64'd0);
      @(negedge clock);
      lat++;
    end

    got = sbQueue.pop_front();
    checkOutput({tag, ".latency"}, 64'(lat), 64'(got.latency));
    checkOutput({tag, ".fault"}, 64'(resp_fault), 64'(got.fault));
    checkOutput({tag, ".data"}, 64'(resp_data), 64'(got.data));

    heldData  = resp_data;
    heldFault = resp_fault;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checkOutput({tag, ".holdValid"}, 64'(resp_valid), 64'd1);
      checkOutput({tag, ".holdData"}, 64'(resp_data), 64'(heldData));
      checkOutput({tag, ".holdFault"}, 64'(resp_fault), 64'(heldFault));
      checkOutput({tag, ".holdReqReady"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;

    @(negedge clock);
    checkOutput({tag, ".respDone"}, 64'(resp_valid), 64'd0);
    checkOutput({tag, ".reqReadyBack"}, 64'(req_ready), 64'd1);
    checkOutput({tag, ".writes"}, 64'(wePulses - startPulses), 64'(got.writes));
    if (got.writes == 1) begin
      checkOutput({tag, ".wrAddr"}, 64'(lastWrAddr), 64'(got.wrAddr));
      checkOutput({tag, ".wrData"}, 64'(lastWrData), 64'(got.wrData));
    end
  endtask

  // Abandons a request mid-ACCESS with reset and confirms no strobe afterwards.
  task automatic resetDuringAccess(input string tag, input logic wr, input logic [31:0] addr);
    int startPulses;
    @(negedge clock);
    req_valid   = 1'b1;
    req_op      = 3'd0;
    req_write   = wr;
    req_address = addr;
    req_data    = 32'hA5A5_0000 | addr;
    is_kernel   = 1'b0;
    resp_ready  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    startPulses = wePulses;
    reset = 1'b1;
    #1;
    checkOutput({tag, ".we"}, 64'(mem_write_enable), 64'd0);
    checkOutput({tag, ".memAddr"}, 64'(mem_address), 64'd0);
    checkOutput({tag, ".memData"}, 64'(mem_write_data), 64'd0);
    checkOutput({tag, ".respValid"}, 64'(resp_valid), 64'd0);
    checkOutput({tag, ".reqReady"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput({tag, ".noStrobe"}, 64'(wePulses - startPulses), 64'd0);
    checkOutput({tag, ".respIdle"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  opSel;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'(i) * 32'd3 + 32'd1;
      shadow[i] = 32'(i) * 32'd3 + 32'd1;
    end
    reset = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_write = 1'b0;
    req_address = '0; req_data = '0; is_kernel = 1'b0; resp_ready = 1'b1;
    #12;
    checkOutput("reset.respValid", 64'(resp_valid), 64'd0);
    checkOutput("reset.respData", 64'(resp_data), 64'd0);
    checkOutput("reset.respFault", 64'(resp_fault), 64'd0);
    checkOutput("reset.we", 64'(mem_write_enable), 64'd0);
    checkOutput("reset.memAddr", 64'(mem_address), 64'd0);
    checkOutput("reset.reqReady", 64'(req_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus("store100", 3'd0, 1'b1, 32'd100, 32'hDEADBEEF, 1'b0, 0);
    applyStimulus("load100", 3'd0, 1'b0, 32'd100, 32'd0, 1'b0, 0);
    applyStimulus("pushK4095", 3'd1, 1'b1, 32'd4095, 32'h1111_2222, 1'b1, 0);
    applyStimulus("pushU6144", 3'd1, 1'b1, 32'd6144, 32'h3333_4444, 1'b0, 0);
    applyStimulus("popU6144", 3'd2, 1'b0, 32'd6144, 32'd0, 1'b0, 0);
    applyStimulus("popK6144", 3'd2, 1'b0, 32'd6144, 32'd0, 1'b1, 0);
    applyStimulus("load4095", 3'd0, 1'b0, 32'd4095, 32'd0, 1'b0, 0);
    applyStimulus("load8192", 3'd0, 1'b0, 32'd8192, 32'd0, 1'b0, 0);
    applyStimulus("alu8192", 3'd3, 1'b1, 32'd8192, 32'h5555_6666, 1'b1, 0);
    applyStimulus("brMax", 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    applyStimulus("load8191", 3'd0, 1'b0, 32'd8191, 32'd0, 1'b0, 0);
    applyStimulus("backpress", 3'd0, 1'b0, 32'd100, 32'd0, 1'b0, 5);
    applyStimulus("faultHold", 3'd0, 1'b0, 32'd9000, 32'd0, 1'b0, 3);

    for (int i = 0; i < 5; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1));
      d = $urandom;
      opSel = (i % 3 == 0) ? 3'd0 : ((i % 3 == 1) ? 3'd3 : 3'd4);
      applyStimulus("rndStore", opSel, 1'b1, a, d, 1'b0, 0);
      applyStimulus("rndLoad", opSel, 1'b0, a, 32'd0, 1'b1, i % 2);
    end

    resetDuringAccess("rstStore", 1'b1, 32'd200);
    resetDuringAccess("rstLoad", 1'b0, 32'd300);
    applyStimulus("afterRst", 3'd0, 1'b0, 32'd200, 32'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
